// File: rtl/ascon_serial_io.sv
// Serial-to-parallel front end for an Ascon core: loads key/nonce/AD/data MSB-first,
// starts the core once, then streams ciphertext/plaintext and tag back out LSB-first.
module ascon_serial_io #(
    parameter int KEY_W  = 128,
    parameter int AD_W   = 40,
    parameter int DATA_W = 104,
    parameter int HOLD   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              keyxSI,
    input  logic              noncexSI,
    input  logic              associated_dataxSI,
    input  logic              input_dataxSI,
    input  logic              ascon_startxSI,
    input  logic              decrypt,
    output logic [KEY_W-1:0]  key,
    output logic [KEY_W-1:0]  nonce,
    output logic [AD_W-1:0]   associated_data,
    output logic [DATA_W-1:0] input_data,
    output logic              core_start,
    output logic              core_decrypt,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_output,
    input  logic [KEY_W-1:0]  core_tag,
    output logic              output_dataxSO,
    output logic              tagxSO,
    output logic              ascon_readyxSO
);

    localparam int MAX_KA = (KEY_W > AD_W) ? KEY_W : AD_W;
    localparam int MAX_W  = (MAX_KA > DATA_W) ? MAX_KA : DATA_W;

    localparam logic [7:0] MAX_C     = 8'(MAX_W);
    localparam logic [7:0] KEY_C     = 8'(KEY_W);
    localparam logic [7:0] AD_C      = 8'(AD_W);
    localparam logic [7:0] DATA_C    = 8'(DATA_W);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
    localparam logic [7:0] MAX_LAST  = 8'(MAX_W - 1);

    typedef enum logic [2:0] {
        LOAD,
        BUSY,
        HOLD_ST,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       cnt;
    logic [MAX_W-1:0] out_sr;
    logic [MAX_W-1:0] tag_sr;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (ascon_startxSI && cnt == MAX_C) state_nxt = BUSY;
            BUSY:    if (core_done) state_nxt = HOLD_ST;
            HOLD_ST: if (cnt == HOLD_LAST) state_nxt = SHIFT;
            SHIFT:   if (cnt == MAX_LAST) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= LOAD;
            cnt             <= '0;
            key             <= '0;
            nonce           <= '0;
            associated_data <= '0;
            input_data      <= '0;
            out_sr          <= '0;
            tag_sr          <= '0;
            core_start      <= 1'b0;
            core_decrypt    <= 1'b0;
            ascon_readyxSO  <= 1'b0;
        end else begin
            state      <= state_nxt;
            core_start <= 1'b0;
            case (state)
                LOAD: begin
                    // Shorter fields keep the first width(F) bits presented.
                    if (cnt < MAX_C)  cnt <= cnt + 8'd1;
                    if (cnt < KEY_C) begin
                        key   <= {key[KEY_W-2:0], keyxSI};
                        nonce <= {nonce[KEY_W-2:0], noncexSI};
                    end
                    if (cnt < AD_C)   associated_data <= {associated_data[AD_W-2:0], associated_dataxSI};
                    if (cnt < DATA_C) input_data <= {input_data[DATA_W-2:0], input_dataxSI};
                    if (state_nxt == BUSY) begin
                        core_start   <= 1'b1;
                        core_decrypt <= decrypt;
                    end
                end
                BUSY: begin
                    if (core_done) begin
                        out_sr         <= MAX_W'(core_output);
                        tag_sr         <= MAX_W'(core_tag);
                        ascon_readyxSO <= 1'b1;
                        cnt            <= '0;
                    end
                end
                HOLD_ST: cnt <= (cnt == HOLD_LAST) ? 8'd0 : cnt + 8'd1;
                SHIFT: begin
                    out_sr <= out_sr >> 1;
                    tag_sr <= tag_sr >> 1;
                    cnt    <= cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign output_dataxSO = ascon_readyxSO & out_sr[0];
    assign tagxSO         = ascon_readyxSO & tag_sr[0];

endmodule

// File: tb/tb_ascon_serial_io.sv
// Directed self-checking bench for ascon_serial_io: serial load, start gating,
// encrypt/decrypt result streaming with a hand-driven core model, and abort by reset.
module tb_ascon_serial_io;

    localparam int KEY_W  = 128;
    localparam int AD_W   = 40;
    localparam int DATA_W = 104;
    localparam int HOLD   = 2;
    localparam int MAX_W  = 128;

    localparam logic [127:0] KEY   = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
    localparam logic [127:0] NONCE = 128'h05885e606e1271b8d47a74c7b297a318;
    localparam logic [39:0]  AD    = 40'h4153434f4e;
    localparam logic [103:0] PT    = 104'h6173636f6e2d756e6963617373;
    localparam logic [103:0] CT    = 104'h18490112f8d5867a830748390b;
    localparam logic [127:0] TAG1  = 128'h3c1f2a5d7e9b0c4a86f1d2e3b4c5a697;
    localparam logic [127:0] TAG2  = 128'ha5c3e1f00f1e3c5a9687b4d2e1f0c3a5;

    logic              clk = 1'b0;
    logic              rst;
    logic              keyxSI, noncexSI, associated_dataxSI, input_dataxSI;
    logic              ascon_startxSI, decrypt;
    logic [KEY_W-1:0]  key, nonce;
    logic [AD_W-1:0]   associated_data;
    logic [DATA_W-1:0] input_data;
    logic              core_start, core_decrypt;
    logic              core_done;
    logic [DATA_W-1:0] core_output;
    logic [KEY_W-1:0]  core_tag;
    logic              output_dataxSO, tagxSO, ascon_readyxSO;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    int p0;
    logic [127:0] cap_o, cap_t;

    always #5 clk = ~clk;

    ascon_serial_io #(
        .KEY_W(KEY_W), .AD_W(AD_W), .DATA_W(DATA_W), .HOLD(HOLD)
    ) dut (
        .clk(clk), .rst(rst),
        .keyxSI(keyxSI), .noncexSI(noncexSI),
        .associated_dataxSI(associated_dataxSI), .input_dataxSI(input_dataxSI),
        .ascon_startxSI(ascon_startxSI), .decrypt(decrypt),
        .key(key), .nonce(nonce), .associated_data(associated_data), .input_data(input_data),
        .core_start(core_start), .core_decrypt(core_decrypt),
        .core_done(core_done), .core_output(core_output), .core_tag(core_tag),
        .output_dataxSO(output_dataxSO), .tagxSO(tagxSO), .ascon_readyxSO(ascon_readyxSO)
    );

    // Counts cycles with core_start high (value before the edge's updates).
    always @(posedge clk) if (core_start === 1'b1) n_pulses <= n_pulses + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_random_bits();
        keyxSI             = 1'($urandom);
        noncexSI           = 1'($urandom);
        associated_dataxSI = 1'($urandom);
        input_dataxSI      = 1'($urandom);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        ascon_startxSI = 1'b0;
        core_done      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_fields(input logic [127:0] k, input logic [127:0] n,
                               input logic [39:0] a, input logic [103:0] d);
        for (int i = 0; i < MAX_W; i++) begin
            drive_random_bits();
            keyxSI   = k[127-i];
            noncexSI = n[127-i];
            if (i < AD_W)   associated_dataxSI = a[39-i];
            if (i < DATA_W) input_dataxSI = d[103-i];
            @(negedge clk);
        end
    endtask

    task automatic capture(output logic [127:0] o, output logic [127:0] t);
        o = '0;
        t = '0;
        for (int i = 0; i < MAX_W; i++) begin
            o[i] = output_dataxSO;
            t[i] = tagxSO;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        keyxSI = 1'b0; noncexSI = 1'b0; associated_dataxSI = 1'b0; input_dataxSI = 1'b0;
        ascon_startxSI = 1'b0; decrypt = 1'b0;
        core_done = 1'b0; core_output = '0; core_tag = '0;

        // Reset state
        #3;
        check("rst_key", key, 0);
        check("rst_nonce", nonce, 0);
        check("rst_ad", associated_data, 0);
        check("rst_data", input_data, 0);
        check("rst_ctl", {core_start, core_decrypt, ascon_readyxSO, output_dataxSO, tagxSO}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Start with cnt = 100 is ignored
        for (int i = 0; i < 100; i++) begin
            drive_random_bits();
            @(negedge clk);
        end
        p0 = n_pulses;
        ascon_startxSI = 1'b1;
        @(negedge clk);
        ascon_startxSI = 1'b0;
        repeat (3) @(negedge clk);
        check("early_start_pulses", 128'(n_pulses - p0), 0);
        check("early_start_state", 128'(int'(dut.state)), 0);
        check("early_start_cnt", 128'(dut.cnt), 104);
        check("early_start_ready", ascon_readyxSO, 0);

        // Encrypt pass
        do_reset();
        load_fields(KEY, NONCE, AD, PT);
        check("load_key", key, KEY);
        check("load_nonce", nonce, NONCE);
        check("load_ad", associated_data, AD);
        check("load_data", input_data, PT);
        repeat (5) begin
            drive_random_bits();
            @(negedge clk);
        end
        check("extra_key", key, KEY);
        check("extra_nonce", nonce, NONCE);
        check("extra_ad", associated_data, AD);
        check("extra_data", input_data, PT);

        decrypt = 1'b0;
        p0 = n_pulses;
        ascon_startxSI = 1'b1;
        repeat (4) @(negedge clk);
        check("enc_pulses", 128'(n_pulses - p0), 1);
        check("enc_core_decrypt", core_decrypt, 0);
        check("enc_busy_ready", ascon_readyxSO, 0);
        core_output = CT;
        core_tag    = TAG1;
        core_done   = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("enc_ready_rise", ascon_readyxSO, 1);
        repeat (HOLD) @(negedge clk);
        capture(cap_o, cap_t);
        check("enc_ct_stream", cap_o, {24'h0, CT});
        check("enc_tag_stream", cap_t, TAG1);
        check("enc_done_outs", {ascon_readyxSO, output_dataxSO, tagxSO}, 3'b100);
        core_output = '1;
        core_tag    = '1;
        core_done   = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
        check("done_ignores_core", {ascon_readyxSO, output_dataxSO, tagxSO}, 3'b100);
        check("enc_pulses_total", 128'(n_pulses - p0), 1);
        ascon_startxSI = 1'b0;

        // Decrypt pass
        do_reset();
        load_fields(KEY, NONCE, AD, CT);
        check("dec_load_data", input_data, CT);
        decrypt = 1'b1;
        p0 = n_pulses;
        ascon_startxSI = 1'b1;
        @(negedge clk);
        ascon_startxSI = 1'b0;
        decrypt = 1'b0;
        repeat (3) @(negedge clk);
        check("dec_pulses", 128'(n_pulses - p0), 1);
        check("dec_core_decrypt", core_decrypt, 1);
        core_output = PT;
        core_tag    = TAG2;
        core_done   = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("dec_ready_rise", ascon_readyxSO, 1);
        repeat (HOLD) @(negedge clk);
        capture(cap_o, cap_t);
        check("dec_pt_stream", cap_o, {24'h0, PT});
        check("dec_tag_stream", cap_t, TAG2);

        // Reset during BUSY aborts; late core_done ignored
        do_reset();
        load_fields(KEY, NONCE, AD, PT);
        p0 = n_pulses;
        ascon_startxSI = 1'b1;
        @(negedge clk);
        ascon_startxSI = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_fields", {key, nonce} | {associated_data, input_data}, 0);
        check("abort_ctl", {core_start, core_decrypt, ascon_readyxSO, output_dataxSO, tagxSO}, 0);
        check("abort_state", 128'(int'(dut.state)), 0);
        check("abort_cnt", 128'(dut.cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        core_output = CT;
        core_tag    = TAG1;
        core_done   = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("late_done_ready", ascon_readyxSO, 0);
        check("late_done_state", 128'(int'(dut.state)), 0);
        check("late_done_cnt", 128'(dut.cnt), 1);
        repeat (3) @(negedge clk);
        check("late_done_outs", {ascon_readyxSO, output_dataxSO, tagxSO, core_start}, 0);
        check("abort_pulses", 128'(n_pulses - p0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
